// File: rtl/keypad_driver_pkg.sv
// Shared definitions for the 4x4 keypad driver: FSM states, bus addresses,
// read-word field positions and the column priority helper.
package keypad_driver_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  localparam logic [1:0] KEYPAD_ADDR_DATA   = 2'b00;
  localparam logic [1:0] KEYPAD_ADDR_STATUS = 2'b10;

  localparam int RD_VALID_BIT = 15;
  localparam int RD_OVF_BIT   = 14;
  localparam int RD_CNT_MSB   = 10;
  localparam int RD_CNT_LSB   = 8;
  localparam int RD_CODE_MSB  = 3;
  localparam int RD_CODE_LSB  = 0;

  localparam int FIFO_DEPTH = 4;

  // Lowest-numbered active-low column wins when several are pressed.
  function automatic logic [1:0] lowest_low(input logic [3:0] col);
    if (!col[0])      return 2'd0;
    else if (!col[1]) return 2'd1;
    else if (!col[2]) return 2'd2;
    else              return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_fifo.sv
// Four-entry key-code FIFO; a push into a full FIFO succeeds only when a pop
// happens on the same edge.
module keypad_fifo
  import keypad_driver_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [3:0] din,
  output logic [3:0] dout,
  output logic       full,
  output logic       empty,
  output logic [2:0] count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [3:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == 3'(FIFO_DEPTH));
  assign empty   = (count == 3'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 3'd0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + {2'b00, do_push} - {2'b00, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/keypad_driver.sv
// 4x4 matrix keypad scanner with debounce and a CPU-readable key FIFO.
// Define KEYPAD_REPEAT_EN to re-push a held key every REPEAT_SLOTS slot-ends.
//
// state       | meaning
// ST_SCAN     | rotating the driven row, waiting for any low column
// ST_DEBOUNCE | row frozen, counting stable low samples of latched column
// ST_HELD     | key accepted, counting stable high samples for release
module keypad_driver
  import keypad_driver_pkg::*;
#(
  parameter int SCAN_DIV       = 20000,
  parameter int DEBOUNCE_SLOTS = 4,
  parameter int REPEAT_SLOTS   = 64
)(
  input  logic        iCpuClock,
  input  logic        iCpuReset,
  input  logic [3:0]  iKeypadCol,
  output logic [3:0]  oKeypadRow,
  input  logic        iDoKeypadRead,
  input  logic [1:0]  iKeypadAddress,
  output logic [15:0] oKeypadReadData
);

  localparam int SLOT_W  = $clog2(SCAN_DIV);
  localparam int CNT_MAX = (DEBOUNCE_SLOTS > REPEAT_SLOTS) ? DEBOUNCE_SLOTS : REPEAT_SLOTS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_SLOTS - 1);

  logic [3:0]        col_meta;
  logic [3:0]        col_sync;
  logic [SLOT_W-1:0] slot_cnt;
  logic              slot_end;
  state_t            state, state_nxt;
  logic [1:0]        row_idx, row_nxt;
  logic [3:0]        code, code_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              key_low;
  logic              accept;
  logic              repeat_push;
  logic              push_req;
  logic              fifo_pop, fifo_full, fifo_empty;
  logic [2:0]        fifo_count;
  logic [3:0]        fifo_head;
  logic              ovf;
  logic              is_data, is_status;
  logic [15:0]       rd_word;

  assign slot_end   = (slot_cnt == SLOT_LAST);
  assign key_low    = ~col_sync[code[1:0]];
  assign oKeypadRow = ~(4'b0001 << row_idx);

  always_ff @(posedge iCpuClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= iKeypadCol;
      col_sync <= col_meta;
    end
  end

  always_ff @(posedge iCpuClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      slot_cnt <= '0;
      state    <= ST_SCAN;
      row_idx  <= 2'd0;
      code     <= 4'h0;
      cnt      <= '0;
      push_req <= 1'b0;
    end else begin
      slot_cnt <= slot_end ? '0 : slot_cnt + SLOT_W'(1);
      state    <= state_nxt;
      row_idx  <= row_nxt;
      code     <= code_nxt;
      cnt      <= cnt_nxt;
      push_req <= accept | repeat_push;
    end
  end

  // One counter serves both the press debounce and the release debounce.
  always_comb begin
    state_nxt = state;
    row_nxt   = row_idx;
    code_nxt  = code;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    if (slot_end) begin
      case (state)
        ST_SCAN: begin
          if (col_sync != 4'hF) begin
            code_nxt  = {row_idx, lowest_low(col_sync)};
            cnt_nxt   = '0;
            state_nxt = ST_DEBOUNCE;
          end else begin
            row_nxt = row_idx + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (key_low) begin
            if (cnt == DEB_LAST) begin
              accept    = 1'b1;
              cnt_nxt   = '0;
              state_nxt = ST_HELD;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end else begin
            cnt_nxt   = '0;
            state_nxt = ST_SCAN;
            row_nxt   = row_idx + 2'd1;
          end
        end
        ST_HELD: begin
          if (key_low) begin
            cnt_nxt = '0;
          end else if (cnt == DEB_LAST) begin
            cnt_nxt   = '0;
            state_nxt = ST_SCAN;
            row_nxt   = row_idx + 2'd1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: state_nxt = ST_SCAN;
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_SLOTS - 1);
  logic [CNT_W-1:0] rep_cnt, rep_cnt_nxt;

  always_ff @(posedge iCpuClock or posedge iCpuReset) begin
    if (iCpuReset) rep_cnt <= '0;
    else           rep_cnt <= rep_cnt_nxt;
  end

  always_comb begin
    rep_cnt_nxt = rep_cnt;
    repeat_push = 1'b0;
    if (state != ST_HELD) begin
      rep_cnt_nxt = '0;
    end else if (slot_end) begin
      if (!key_low) begin
        rep_cnt_nxt = '0;
      end else if (rep_cnt == REP_LAST) begin
        rep_cnt_nxt = '0;
        repeat_push = 1'b1;
      end else begin
        rep_cnt_nxt = rep_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign repeat_push = 1'b0;
`endif

  assign is_data   = (iKeypadAddress == KEYPAD_ADDR_DATA);
  assign is_status = (iKeypadAddress == KEYPAD_ADDR_STATUS);
  assign fifo_pop  = iDoKeypadRead && is_data && !fifo_empty;

  keypad_fifo u_fifo (
    .clk   (iCpuClock),
    .rst   (iCpuReset),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   (code),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A dropped push beats a same-edge DATA read clearing the flag.
  always_ff @(posedge iCpuClock or posedge iCpuReset) begin
    if (iCpuReset)                                ovf <= 1'b0;
    else if (push_req && fifo_full && !fifo_pop)  ovf <= 1'b1;
    else if (iDoKeypadRead && is_data)            ovf <= 1'b0;
  end

  always_comb begin
    rd_word                            = 16'h0000;
    rd_word[RD_VALID_BIT]              = ~fifo_empty;
    rd_word[RD_OVF_BIT]                = ovf;
    rd_word[RD_CNT_MSB:RD_CNT_LSB]     = fifo_count;
    rd_word[RD_CODE_MSB:RD_CODE_LSB]   = fifo_empty ? 4'h0 : fifo_head;
  end

  assign oKeypadReadData = (is_data || is_status) ? rd_word : 16'h0000;

endmodule

// File: tb/tb_keypad_driver.sv
// Bench for keypad_driver: a switch-matrix model drives the columns from the
// row outputs, and a queue-based model of the key FIFO predicts read words.
module tb_keypad_driver;

  localparam int SD = 4;
  localparam int DS = 3;
  localparam int RS = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        rd;
  logic [1:0]  addr;
  logic [15:0] rdata;
  logic [15:0] pressed;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [3:0]  q[$];
  bit          ovf_m;

  logic [15:0] w;
  logic [15:0] exp_w;
  logic [15:0] mask;
  logic [3:0]  code;
  logic [3:0]  cm;
  logic [3:0]  exp_row;
  int          rr;
  int          n_rep;
  bit          ok;

  keypad_driver #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_SLOTS (DS),
    .REPEAT_SLOTS   (RS)
  ) dut (
    .iCpuClock       (clk),
    .iCpuReset       (rst),
    .iKeypadCol      (col),
    .oKeypadRow      (row),
    .iDoKeypadRead   (rd),
    .iKeypadAddress  (addr),
    .oKeypadReadData (rdata)
  );

  always #5 clk = ~clk;

  // Switch matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  function automatic logic [15:0] model_word();
    int n = q.size();
    logic [15:0] v = 16'h0000;
    if (n > 0) v = 16'h8000 + 16'(n * 256) + {12'h000, q[0]};
    if (ovf_m) v = v | 16'h4000;
    return v;
  endfunction

  function automatic void model_push(input logic [3:0] c);
    if (q.size() >= 4) ovf_m = 1'b1;
    else               q.push_back(c);
  endfunction

  function automatic logic [15:0] model_data_read();
    logic [15:0] v = model_word();
    if (q.size() > 0) void'(q.pop_front());
    ovf_m = 1'b0;
    return v;
  endfunction

  function automatic logic [3:0] code_of(input int r, input logic [3:0] cols);
    int lc = 0;
    for (int c = 3; c >= 0; c--) if (cols[c]) lc = c;
    return 4'(r * 4 + lc);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv)
      else begin
        n_fails++;
        $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_bus(input logic [1:0] a, output logic [15:0] v);
    addr = a;
    rd   = 1'b1;
    #1;
    v = rdata;
    @(posedge clk);
    #1;
    rd = 1'b0;
  endtask

  task automatic peek_status(input string tag);
    addr = 2'b10;
    #1;
    check(tag, rdata, model_word());
  endtask

  task automatic status_check(input string tag);
    logic [15:0] v;
    logic [15:0] e;
    e = model_word();
    read_bus(2'b10, v);
    check(tag, v, e);
  endtask

  task automatic data_check(input string tag);
    logic [15:0] v;
    logic [15:0] e;
    e = model_data_read();
    read_bus(2'b00, v);
    check(tag, v, e);
  endtask

  task automatic press(input logic [15:0] m, input int hold);
    pressed = m;
    repeat (hold) tick();
    pressed = 16'h0000;
    repeat (30) tick();
  endtask

  // Returns just after the edge on which the scanner moved onto row r.
  task automatic wait_row(input int r, output bit found);
    logic [3:0] want;
    logic [3:0] prev;
    want  = ~(4'b0001 << r);
    prev  = row;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      tick();
      if (row == want && prev != want) found = 1'b1;
      prev = row;
    end
    check("row_sync", {15'h0, found}, 16'h0001);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    rd      = 1'b0;
    addr    = 2'b10;
    pressed = 16'h0000;
    ovf_m   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_row", {12'h000, row}, 16'h000E);
    addr = 2'b10; #1; check("reset_status", rdata, 16'h0000);
    addr = 2'b00; #1; check("reset_data", rdata, 16'h0000);
    addr = 2'b01; #1; check("reset_addr01", rdata, 16'h0000);
    rst = 1'b0;

    for (int n = 1; n <= 16; n++) begin
      tick();
      exp_row = ~(4'b0001 << ((n / SD) % 4));
      check("row_cycle", {12'h000, row}, {12'h000, exp_row});
    end

    // Row 1 / column 2 held for 40 cycles.
    press(16'h0040, 40);
    model_push(4'h6);
    status_check("status_key6");
    addr = 2'b10; #1; check("status_key6_abs", rdata, 16'h8106);
    read_bus(2'b01, w); check("addr01_read", w, 16'h0000);
    read_bus(2'b11, w); check("addr11_read", w, 16'h0000);
    status_check("status_after_bad_addr");
    data_check("data_key6");
    status_check("status_after_pop");

    // Bounce: one low slot-end then high.
    wait_row(2, ok);
    pressed = 16'h0200;
    repeat (4) tick();
    check("bounce_frozen", {12'h000, row}, 16'h000B);
    pressed = 16'h0000;
    repeat (4) tick();
    check("bounce_resume", {12'h000, row}, 16'h0007);
    peek_status("bounce_no_push");

    // Press latency: push lands DS*SD+1 cycles after the detecting slot end.
    wait_row(2, ok);
    pressed = 16'h0200;
    repeat (SD + DS * SD) tick();
    peek_status("latency_before");
    tick();
    model_push(4'h9);
    peek_status("latency_at");
    repeat (20) tick();
    pressed = 16'h0000;
    repeat (30) tick();
    peek_status("single_push");
    data_check("data_key9");

    // Five random presses with no reads: overflow.
    for (int i = 0; i < 5; i++) begin
      rr   = int'($urandom_range(0, 3));
      cm   = 4'($urandom_range(1, 15));
      mask = 16'({12'h000, cm} << (rr * 4));
      code = code_of(rr, cm);
      press(mask, 40);
      model_push(code);
    end
    status_check("status_overflow");
    data_check("data_overflow");
    status_check("status_after_ovf_pop");

    rr   = int'($urandom_range(0, 3));
    cm   = 4'($urandom_range(1, 15));
    mask = 16'({12'h000, cm} << (rr * 4));
    press(mask, 40);
    model_push(code_of(rr, cm));
    status_check("status_full");

    // Pop and push on the same edge while full.
    wait_row(0, ok);
    pressed = 16'h0008;
    repeat (SD + DS * SD) tick();
    exp_w = model_data_read();
    read_bus(2'b00, w);
    model_push(4'h3);
    check("data_simul", w, exp_w);
    peek_status("status_simul");
    repeat (15) tick();
    pressed = 16'h0000;
    repeat (30) tick();
    status_check("status_simul_after");

    for (int i = 0; i < 4; i++) data_check("drain");
    data_check("data_empty");
    addr = 2'b00; #1; check("data_empty_abs", rdata, 16'h0000);
    status_check("status_empty");

    // Reset in the middle of a press.
    press(16'h0010, 40);
    model_push(4'h4);
    status_check("status_pre_reset");
    pressed = 16'h0001;
    repeat (10) tick();
    rst = 1'b1;
    #1;
    q.delete();
    ovf_m = 1'b0;
    check("midreset_row", {12'h000, row}, 16'h000E);
    peek_status("midreset_status");
    tick();
    tick();
    rst = 1'b0;
    repeat (40) tick();
    pressed = 16'h0000;
    repeat (30) tick();
    model_push(4'h0);
    status_check("held_through_reset");
    data_check("data_after_reset");

    // Key F held for 30 slot-ends.
    wait_row(3, ok);
    pressed = 16'h8000;
    repeat (30 * SD) tick();
    pressed = 16'h0000;
    repeat (30) tick();
`ifdef KEYPAD_REPEAT_EN
    n_rep = 1 + (30 - DS) / RS;
`else
    n_rep = 1;
`endif
    for (int i = 0; i < n_rep; i++) model_push(4'hF);
    status_check("repeat_count");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
